keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Matrix-keypad input block for the FPGA top level: the user-to-CPU counterpart of the multiplexed seven-segment output path. It drives a 4x4 keypad's rows one at a time, the same way the display driver strobes its digit enables. It samples the columns, debounces whole-matrix snapshots and turns each clean single-key press into a 4-bit key code. The CPU-side logic consumes the code through a valid/ack handshake.

## Interface
- SCAN_DIV, 1000: clk cycles each row stays driven; must be >= 4.
- DEBOUNCE, 4: consecutive identical frame snapshots required before the debounced state updates; must be >= 1.
- clk  in  1  system clock.
- clr_n  in  1  reset, asynchronous, active-low.
- row_en  out  4  row drive, active-low one-hot; bit r low means row r is driven.
- col_in  in  4  column sense, active-low (pulled up externally), asynchronous to clk.
- key_code  out  4  code of last accepted press, row*4+col.
- key_valid  out  1  key_code holds an unconsumed press.
- key_ack  in  1  consumer accepts key_code; sampled on rising clk.
- key_held  out  1  debounced state has at least one key down.
- overrun  out  1  sticky flag: a press was dropped because key_valid was already high.

## Operation
- col_in passes through a 2-flop synchronizer before any use.
- Row sequencer:
  - A counter runs 0..SCAN_DIV-1, then wraps.
  - On wrap, the active row advances 0→1→2→3→0.
  - row_en = ~(1<<row).
- Sampling:
  - At counter value SCAN_DIV-1, the synchronized columns are inverted.
  - The result is stored into snapshot bits [row*4+3:row*4]; bit row*4+c = key (row,c) pressed.
- Frame end: the sample of row 3 completes a 16-bit frame snapshot. At frame end:
  - If snapshot == previous snapshot: stable_cnt increments, saturating at DEBOUNCE. Otherwise stable_cnt is set to 1.
  - previous snapshot <= snapshot.
  - When stable_cnt reaches DEBOUNCE (i.e. DEBOUNCE identical consecutive frames), debounced <= snapshot.
- Press event:
  - Fires when debounced changes from all-zero to a value with exactly one bit set.
  - The event's code is the index of that bit.
  - Multi-key results (0→2+ bits, or 1 bit→2 bits) generate no event.
  - Changing from one key directly to another without passing through all-zero generates no event.
- Handshake:
  - On an event with key_valid=0: key_code <= code, key_valid <= 1.
  - Cycle with key_valid=1 and key_ack=1: key_valid <= 0, overrun <= 0.
  - Event with key_valid=1 and no ack in the same cycle: key_code is unchanged and overrun <= 1.
  - Event and ack in the same cycle: the new code loads, key_valid stays 1, and overrun is cleared (no drop).
  - key_ack while key_valid=0 is ignored.
- key_held = |debounced (registered).

## Timing
- Reset values:
  - row_en=4'b1110, scan counter 0, row 0.
  - snapshot, previous and debounced all 0; stable_cnt 0.
  - key_code=0, key_valid=0, key_held=0, overrun=0.
  - Synchronizer flops 4'b1111.
- Frame period: 4*SCAN_DIV cycles. Each row is sampled SCAN_DIV-1 cycles after it is driven, which covers settling plus the 2-cycle sync.
- Press latency:
  - The key must be seen in DEBOUNCE consecutive frame snapshots, counting the first frame it appears in.
  - key_valid rises 1 cycle after the frame-end edge at which stable_cnt reaches DEBOUNCE.
  - Worst case from a stable press is (DEBOUNCE+1) frames + 2 cycles.
- Release is debounced identically; key_held falls 1 cycle after the debounced update.
- key_valid falls the cycle after ack; key_code is not cleared on ack.
- Asserting clr_n low mid-scan or mid-handshake returns everything to reset values immediately. No event is generated on exit from reset.
- An input that toggles every frame never reaches the stable count; the debounced state holds its prior value.

## Test plan
- Bench parameters: SCAN_DIV=4, DEBOUNCE=3.
- Reset/scan: release clr_n → row_en cycles 1110,1101,1011,0111 every 4 clks. key_valid=0 and overrun=0 throughout with no keys pressed.
- Single press: hold key (2,1) so col_in[1]=0 while row_en[2]=0 → key_valid=1, key_code=9, key_held=1 within 4 frames + 2 clks. Pulse key_ack → key_valid=0 next cycle, key_code stays 9.
- Bounce: toggle key (0,3) every frame for 10 frames → no key_valid. Then hold it stable → key_code=3.
- Multi-key: hold (1,0) and (3,3) together from idle → no event, key_held=1. Release both, then press (3,3) alone → key_code=15.
- Overrun: press and release (0,0) with no ack, then press (1,2) → key_code=0, overrun=1. Ack in the same cycle as a third event (press 5) → key_code=5, key_valid=1, overrun=0.
- Async reset mid-frame with a key held → all outputs at reset values immediately. After release, the held key produces a fresh event with key_code=9 after the full debounce latency.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad front end.
// Strobes one row at a time, samples the synchronized columns once per row,
// debounces whole 16-key frame snapshots and reports each clean single-key
// press as a 4-bit code (row*4+col) through a valid/ack handshake.
module keypad_scanner #(
   parameter int SCAN_DIV = 1000,  // clk cycles per row, >= 4
   parameter int DEBOUNCE = 4      // identical frames needed, >= 1
) (
   input  logic       clk,
   input  logic       clr_n,
   output logic [3:0] row_en,
   input  logic [3:0] col_in,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ack,
   output logic       key_held,
   output logic       overrun
);

   localparam int                CNT_W    = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam int                STB_W    = $clog2(DEBOUNCE + 1);
   localparam logic [STB_W-1:0]  STB_FULL = STB_W'(DEBOUNCE);

   logic [3:0]       col_meta;
   logic [3:0]       col_sync;
   logic [CNT_W-1:0] scan_cnt;
   logic [1:0]       row;
   logic [11:0]      snap_lo;     // rows 0..2 of the frame in progress
   logic [15:0]      prev_snap;
   logic [15:0]      debounced;
   logic [15:0]      deb_last;    // debounced one cycle ago, for edge detection
   logic [STB_W-1:0] stable_cnt;

   logic             sample_now;
   logic [3:0]       row_keys;
   logic [15:0]      frame_snap;
   logic [STB_W-1:0] stable_next;
   logic             press_event;
   logic [3:0]       press_code;

   assign row_en = ~(4'b0001 << row);

   // Sample point, current row's pressed keys, the completed frame and the next stable count.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      sample_now  = (scan_cnt == CNT_LAST);
      row_keys    = ~col_sync;
      frame_snap  = {row_keys, snap_lo};
      stable_next = STB_W'(1);
      if (frame_snap == prev_snap)
         stable_next = (stable_cnt == STB_FULL) ? STB_FULL : stable_cnt + STB_W'(1);
   end

   // A press is a move from nothing held to exactly one key held; code is that key's index.
   always_comb begin
      press_event = (deb_last == 16'h0000) && $onehot(debounced);
      press_code  = 4'd0;
      for (int i = 0; i < 16; i++)
         if (debounced[i]) press_code = 4'(i);
   end

   // Two-flop synchronizer for the asynchronous column lines (idle high).
   always_ff @(posedge clk or negedge clr_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      if (!clr_n) begin
         col_meta <= 4'hF;
         col_sync <= 4'hF;
      end else begin
         col_meta <= col_in;
         col_sync <= col_meta;
      end
   end

   // Row sequencer: each row is driven for SCAN_DIV cycles, then the next row takes over.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         scan_cnt <= '0;
         row      <= 2'd0;
      end else if (sample_now) begin
         scan_cnt <= '0;
         row      <= row + 2'd1;
      end else begin
         scan_cnt <= scan_cnt + CNT_W'(1);
      end
   end

   // Capture each row's keys; row 3 closes the frame and runs the debounce comparison.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         snap_lo    <= '0;
         prev_snap  <= '0;
         stable_cnt <= '0;
         debounced  <= '0;
      end else if (sample_now) begin
         case (row)
            2'd0:    snap_lo[3:0]  <= row_keys;
            2'd1:    snap_lo[7:4]  <= row_keys;
            2'd2:    snap_lo[11:8] <= row_keys;
            default: begin
               prev_snap  <= frame_snap;
               stable_cnt <= stable_next;
               if (stable_next == STB_FULL)
                  debounced <= frame_snap;
            end
         endcase
      end
   end

   // Consumer handshake: load on a press, drop and flag overrun if the last code is unread.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         deb_last  <= '0;
         key_held  <= 1'b0;
         key_code  <= 4'd0;
         key_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         deb_last <= debounced;
         key_held <= |debounced;
         if (press_event) begin
            if (!key_valid || key_ack) begin
               key_code  <= press_code;
               key_valid <= 1'b1;
               overrun   <= 1'b0;
            end else begin
               overrun   <= 1'b1;
            end
         end else if (key_valid && key_ack) begin
            key_valid <= 1'b0;
            overrun   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed plus random frame-level stimulus for keypad_scanner.
// A keypad matrix model turns the pressed-key set into column levels; a
// frame-level reference model predicts debounce, press events and handshake.
module tb_keypad_scanner;

   localparam int SCAN_DIV = 4;
   localparam int DEBOUNCE = 3;
   localparam int FRAME    = 4 * SCAN_DIV;

   logic       clk   = 1'b0;
   logic       clr_n = 1'b0;
   logic [3:0] row_en;
   logic [3:0] col_in;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ack = 1'b0;
   logic       key_held;
   logic       overrun;

   logic [15:0] keys = 16'h0000;   // bit row*4+col = key pressed

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model state
   logic [15:0] hist[$];            // frame snapshots since reset, newest last
   logic [15:0] m_deb;
   bit          ev_pend;
   logic [3:0]  ev_code;
   logic [3:0]  m_code;
   logic        m_valid;
   logic        m_ovr;
   logic        m_held;

   keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .row_en    (row_en),
      .col_in    (col_in),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_ack   (key_ack),
      .key_held  (key_held),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   // Keypad matrix: a pressed key on the driven row pulls its column low.
   always_comb begin
      col_in = 4'hF;
      for (int r = 0; r < 4; r++)
         if (row_en == 4'(~(4'b0001 << r))) col_in = ~keys[r*4 +: 4];
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      m_deb   = 16'h0000;
      ev_pend = 1'b0;
      ev_code = 4'd0;
      m_code  = 4'd0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_held  = 1'b0;
   endtask

   // One full scan frame with key set k; ack (if set) is offered on the frame's first edge.
   // Called and returns 1 time unit after a frame-boundary edge.
   task automatic run_frame(input logic [15:0] k, input bit ack);
      logic [3:0] exp_row;
      bit         same;
      keys    = k;
      key_ack = ack;
      @(posedge clk); #1;
      key_ack = 1'b0;
      // First edge of the frame: press from the previous frame end meets the consumer.
      if (ev_pend) begin
         if (!m_valid || ack) begin
            m_code  = ev_code;
            m_valid = 1'b1;
            m_ovr   = 1'b0;
         end else begin
            m_ovr   = 1'b1;
         end
      end else if (m_valid && ack) begin
         m_valid = 1'b0;
         m_ovr   = 1'b0;
      end
      ev_pend = 1'b0;
      m_held  = (m_deb != 16'h0000);
      for (int j = 1; j <= FRAME; j++) begin
         if (j > 1) begin
            @(posedge clk); #1;
         end
         exp_row = ~(4'b0001 << ((j / SCAN_DIV) % 4));
         check("row_en",    row_en,    exp_row);
         check("key_valid", key_valid, m_valid);
         check("key_code",  key_code,  m_code);
         check("key_held",  key_held,  m_held);
         check("overrun",   overrun,   m_ovr);
      end
      // Frame end: debounced follows once the last DEBOUNCE frames agree.
      hist.push_back(k);
      if (hist.size() > DEBOUNCE) void'(hist.pop_front());
      if (hist.size() == DEBOUNCE) begin
         same = 1'b1;
         foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
         if (same && hist[0] != m_deb) begin
            if (m_deb == 16'h0000 && $countones(hist[0]) == 1) begin
               ev_pend = 1'b1;
               for (int b = 0; b < 16; b++) if (hist[0][b]) ev_code = 4'(b);
            end
            m_deb = hist[0];
         end
      end
   endtask

   task automatic frames(input logic [15:0] k, input int n);
      for (int f = 0; f < n; f++) run_frame(k, 1'b0);
   endtask

   // Assert reset after some edges, check outputs at once, release on the next edge.
   task automatic do_reset(input int after_edges, input logic [15:0] k);
      keys = k;
      repeat (after_edges) @(posedge clk);
      #1 clr_n = 1'b0;
      #1;
      check("rst_row_en",    row_en,    4'b1110);
      check("rst_key_valid", key_valid, 1'b0);
      check("rst_key_code",  key_code,  4'd0);
      check("rst_key_held",  key_held,  1'b0);
      check("rst_overrun",   overrun,   1'b0);
      model_reset();
      @(posedge clk); #1 clr_n = 1'b1;
   endtask

   initial begin
      logic [15:0] pat;
      int          len;
      model_reset();

      // Reset and idle scanning
      do_reset(2, 16'h0000);
      frames(16'h0000, 3);

      // Single press of key (2,1): code 9 after three identical frames, then ack
      frames(16'h0001 << 9, 3);
      check("press_not_early", key_valid, 1'b0);
      frames(16'h0001 << 9, 1);
      check("press9_valid", key_valid, 1'b1);
      check("press9_code",  key_code,  4'd9);
      check("press9_held",  key_held,  1'b1);
      run_frame(16'h0001 << 9, 1'b1);
      check("ack_valid_low", key_valid, 1'b0);
      check("ack_code_kept", key_code,  4'd9);
      frames(16'h0000, 4);
      check("release_held", key_held, 1'b0);

      // Bounce: key (0,3) toggles every frame, then settles
      for (int f = 0; f < 10; f++) run_frame((f % 2 == 0) ? 16'h0008 : 16'h0000, 1'b0);
      check("bounce_no_valid", key_valid, 1'b0);
      frames(16'h0008, 4);
      check("bounce_code3", key_code, 4'd3);
      run_frame(16'h0008, 1'b1);
      frames(16'h0000, 4);

      // Multi-key from idle: no event, held only; then (3,3) alone
      frames((16'h0001 << 4) | (16'h0001 << 15), 4);
      check("multi_no_valid", key_valid, 1'b0);
      check("multi_held",     key_held,  1'b1);
      frames(16'h0000, 4);
      frames(16'h0001 << 15, 4);
      check("single15_code", key_code, 4'd15);
      run_frame(16'h0001 << 15, 1'b1);
      frames(16'h0000, 4);

      // Overrun, then ack coinciding with a new press
      frames(16'h0001, 4);
      frames(16'h0000, 4);
      frames(16'h0001 << 6, 4);
      check("ovr_code0", key_code, 4'd0);
      check("ovr_set",   overrun,  1'b1);
      frames(16'h0000, 4);
      frames(16'h0001 << 5, 3);
      run_frame(16'h0001 << 5, 1'b1);
      check("ack_event_code",  key_code,  4'd5);
      check("ack_event_valid", key_valid, 1'b1);
      check("ack_event_ovr",   overrun,   1'b0);
      run_frame(16'h0001 << 5, 1'b1);
      frames(16'h0000, 4);

      // Async reset mid-frame with a key held and a code pending
      frames(16'h0001 << 9, 4);
      do_reset(7, 16'h0001 << 9);
      frames(16'h0001 << 9, 3);
      check("post_rst_wait", key_valid, 1'b0);
      frames(16'h0001 << 9, 1);
      check("post_rst_code", key_code, 4'd9);
      run_frame(16'h0001 << 9, 1'b1);
      frames(16'h0000, 4);

      // Random key patterns and random acks against the model
      for (int n = 0; n < 30; n++) begin
         case ($urandom_range(0, 3))
            0:       pat = 16'h0000;
            1, 2:    pat = 16'h0001 << $urandom_range(0, 15);
            default: pat = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
         endcase
         len = $urandom_range(1, 5);
         for (int f = 0; f < len; f++) run_frame(pat, ($urandom_range(0, 3) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
